// File: rtl/acc_sched.sv
// rtl/acc_sched.sv - round-robin scheduler sharing one accumulator among N requesters
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   req       per-requester job request (sampled only while idle)
//   len       per-requester job length, requester i in [i*LEN_W +: LEN_W]
//   x         per-requester 32-bit operand, requester i in [i*32 +: 32]
//   x_valid   per-requester operand valid
//   x_ready   per-requester operand accept (only the granted bit, only while accumulating)
//   gnt       one-hot grant, held from grant until the result is taken
//   y         accumulated result, modulo 2^W
//   y_id      index of the requester owning y
//   y_valid   result valid
//   y_ready   result consumer ready
//   busy      high whenever a job is in flight
module acc_sched #(
    parameter int N     = 4,
    parameter int ID_W  = 2,
    parameter int W     = 32,
    parameter int LEN_W = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*LEN_W-1:0]   len,
    input  logic [N*32-1:0]      x,
    input  logic [N-1:0]         x_valid,
    output logic [N-1:0]         x_ready,
    output logic [N-1:0]         gnt,
    output logic [W-1:0]         y,
    output logic [ID_W-1:0]      y_id,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state;
    logic [ID_W-1:0]  g;
    logic [ID_W-1:0]  last;
    logic [LEN_W-1:0] len_l;
    logic [LEN_W-1:0] cnt;
    logic [W-1:0]     acc;

    logic [ID_W-1:0]  sel;
    logic             found;
    logic [LEN_W-1:0] len_sel;
    logic [N-1:0]     sel_oh;
    logic [31:0]      xg;
    logic [W-1:0]     xext;
    logic [W-1:0]     sum;

    // Search upward from last+1 so that the most recently served requester
    // has lowest priority on the next arbitration.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[(int'(last) + k) % N]) begin
                found = 1'b1;
                sel   = ID_W'((int'(last) + k) % N);
            end
        end
    end

    assign len_sel = len[int'(sel)*LEN_W +: LEN_W];
    assign sel_oh  = N'(1) << sel;
    assign xg      = x[int'(g)*32 +: 32];

    generate
        if (W > 32) begin : g_ext
            assign xext = {{(W-32){1'b0}}, xg};
        end else begin : g_trunc
            assign xext = xg[W-1:0];
        end
    endgenerate

    assign sum = acc + xext;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            g       <= '0;
            last    <= ID_W'(N-1);
            len_l   <= '0;
            cnt     <= '0;
            acc     <= '0;
            x_ready <= '0;
            gnt     <= '0;
            y       <= '0;
            y_id    <= '0;
            y_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        g     <= sel;
                        len_l <= len_sel;
                        acc   <= '0;
                        cnt   <= '0;
                        gnt   <= sel_oh;
                        busy  <= 1'b1;
                        if (len_sel == '0) begin
                            // Empty job: report a zero result straight away.
                            state   <= DONE;
                            y       <= '0;
                            y_id    <= sel;
                            y_valid <= 1'b1;
                        end else begin
                            state   <= ACC;
                            x_ready <= sel_oh;
                        end
                    end
                end
                ACC: begin
                    if (x_valid[g]) begin
                        acc <= sum;
                        cnt <= cnt + LEN_W'(1);
                        if (cnt == len_l - LEN_W'(1)) begin
                            // Present the final sum in the same edge that
                            // absorbs the last sample.
                            state   <= DONE;
                            x_ready <= '0;
                            y       <= sum;
                            y_id    <= g;
                            y_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (y_ready) begin
                        last    <= g;
                        state   <= IDLE;
                        gnt     <= '0;
                        busy    <= 1'b0;
                        y_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    x_ready <= '0;
                    gnt     <= '0;
                    y_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/acc_sched.md
# acc_sched

Round-robin scheduler that shares one W-bit accumulator among N requesters. Each requester asks for a job of `len` samples and streams 32-bit operands. The scheduler grants one requester at a time, sequences the accumulation with its own sample counter, and returns the sum through a valid/ready result port. It sits between several producer blocks and the single accumulate datapath.

## Interface
Parameters:
- N, 4, number of requesters
- ID_W, 2, width of requester index (must satisfy 2^ID_W >= N)
- W, 32, accumulator/result width
- LEN_W, 7, width of per-job sample count

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset; synchronous, active-low (asserted when 0, sampled on clk rising edge)
- req  input  N  per-requester job request
- len  input  N*LEN_W  per-requester sample count; requester i in bits [i*LEN_W +: LEN_W]
- x  input  N*32  per-requester operand; requester i in bits [i*32 +: 32]
- x_valid  input  N  operand valid per requester
- x_ready  output  N  operand accepted per requester
- gnt  output  N  one-hot grant; held for the whole job
- y  output  W  accumulated result
- y_id  output  ID_W  index of the requester owning y
- y_valid  output  1  result valid
- y_ready  input  1  result consumer ready
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, ACC, DONE.
- IDLE:
  - If any req bit is high, select a requester round-robin, searching upward from (last+1) mod N.
  - Latch the index g and len[g]. Clear acc and cnt.
  - If the latched len is 0, go to DONE with acc=0. Otherwise go to ACC.
- ACC:
  - gnt[g]=1 and x_ready[g]=1. All other x_ready bits are 0.
  - On x_valid[g] & x_ready[g], set acc <= acc + x[g] and cnt <= cnt+1.
  - If cnt == len_latched-1 on an accepted sample, go to DONE.
  - x_valid from non-granted requesters is ignored.
- DONE:
  - y_valid=1, y=acc, y_id=g, gnt[g] still 1.
  - On y_ready, set last <= g and go to IDLE.
  - y and y_id stay stable while y_valid=1 and y_ready=0.
- Arithmetic:
  - x is zero-extended to W if W>32, or truncated to its low W bits if W<32.
  - The sum wraps modulo 2^W, with no saturation or overflow flag.
- req is sampled only in IDLE. Deasserting req[g] mid-job neither aborts nor shortens the job. len[g] changes after the grant are ignored.
- Maximum job length is 2^LEN_W-1. cnt is LEN_W bits and never wraps within a legal job.

## Timing
- Reset (rst=0 at an edge): state IDLE, last=N-1 (so requester 0 has first priority), acc=0, cnt=0. Outputs: gnt=0, x_ready=0, y=0, y_id=0, y_valid=0, busy=0.
- Reset asserted mid-job: the job is discarded with no y_valid, and all outputs take their reset values on the next edge.
- Grant latency: req high in IDLE at edge t gives gnt, busy and x_ready high after edge t. The first sample can be accepted at edge t+1.
- Throughput: one sample per cycle while x_valid[g] is held high.
- Result latency: the last sample accepted at edge k gives y_valid=1 after edge k (DONE state).
- len=0: y_valid=1 with y=0 one cycle after the grant.
- Handback: a y handshake at edge r returns the block to IDLE after r. The next grant appears after edge r+1, so there is one idle cycle between jobs.
- Simultaneous requests: resolved purely by round-robin order from last+1. No requester waits more than N-1 jobs.

## Test plan
- Single job: req[0]=1, len=3, x=5,7,9 with x_valid held high. Require x_ready[0] high 3 cycles, then y_valid with y=21, y_id=0.
- Round-robin: req=4'b1111 held, len=1 each, x[i]=i+1, y_ready=1. Require y_id sequence 0,1,2,3,0 with y=1,2,3,4,1 and one idle cycle between jobs.
- Stalls and backpressure: len=4, x_valid toggling 1,0,1,0,... Require exactly 4 accepts. Then hold y_ready=0 for 5 cycles and require y/y_id stable with y_valid high, then IDLE after the handshake.
- Wrap and edge lengths: W=32, len=2, x=32'hFFFFFFFF,2. Require y=1. A len=0 job returns y=0 one cycle after the grant.
- Reset mid-job: rst=0 during ACC after 2 samples. Require all outputs zero next cycle. The next job from requester 0 sums from 0 with no residue.
